// File: rtl/serial_adder_if.sv
// serial_adder_if: groups the start/busy/done handshake, operands and result
// of the bit-serial adder. The master drives operands and start; the slave
// (the adder) returns busy/done and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus a carry flop,
// operands consumed LSB-first one bit per clock.
// Start accepted at edge 0, busy for WIDTH cycles, done pulse in cycle WIDTH+1.
// sum/c_out/ovf are only updated at the edge that enters DONE, never partial.
// Optional feature macro: SERIAL_ADDER_SUB_EN (subtract via ~b and carry-in 1).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             carry_nx;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             res_lsb_unused;

  // The full-adder cell working on the current LSBs of the operand registers.
  assign bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // New bit enters the MSB of the result register; a 1-bit result is just the bit.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = bit_s;
    end else begin : g_res_wn
      assign res_shift = {bit_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  // The oldest result bit falls off the register before the final latch.
  assign res_lsb_unused = res_q[0];

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; c_in is ignored for a subtract.
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub ? 1'b1   : bus.c_in;
`else
  logic sub_unused;
  assign sub_unused = bus.sub;
  assign b_load     = bus.b;
  assign carry_load = bus.c_in;
`endif

  // Next-state and datapath: load on an accepted start, shift one bit per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_nx;
        res_d   = res_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Last bit: carry_q is the carry into the MSB, carry_nx the carry out.
          sum_d   = res_shift;
          c_out_d = carry_nx;
          ovf_d   = carry_q ^ carry_nx;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // All state and registered outputs; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: WIDTH=8 adder checked every cycle against an arithmetic
// reference with an operation countdown; WIDTH=1 adder checked per operation.
module tb_serial_adder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int vectors    = 0;
  int miscompares = 0;

  // Reference: returns {ovf, c_out, sum[7:0]} for a w-bit operation.
  function automatic logic [9:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
    longint m, ua, ub, sa, sb, t, st;
    logic   co, ov, sub_eff;
    sub_eff = sub & SUB_ON;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub_eff) begin
      t  = ua - ub;
      co = (ua >= ub);
      st = sa - sb;
    end else begin
      t  = ua + ub + longint'(cin);
      co = (t >= m);
      st = sa + sb + longint'(cin);
    end
    ov = (st < -(m / 2)) || (st > (m / 2 - 1));
    return {ov, co, 8'(t & (m - 1))};
  endfunction

  // Model of the WIDTH=8 instance: countdown of remaining busy cycles.
  int         remain   = 0;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic [9:0] exp_res  = '0;
  logic [9:0] pend_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain   <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_res  <= '0;
    end else if (remain == 0) begin
      exp_done <= 1'b0;
      if (bus8.start) begin
        pend_res <= ref_add(8, bus8.a, bus8.b, bus8.c_in, bus8.sub);
        remain   <= 8;
        exp_busy <= 1'b1;
      end else begin
        exp_busy <= 1'b0;
      end
    end else begin
      remain <= remain - 1;
      if (remain == 1) begin
        exp_busy <= 1'b0;
        exp_done <= 1'b1;
        exp_res  <= pend_res;
      end
    end
  end

  // Per-cycle comparison of the WIDTH=8 outputs against the model.
  always @(negedge clk) begin
    vectors++;
    if (bus8.busy !== exp_busy || bus8.done !== exp_done ||
        {bus8.ovf, bus8.c_out, bus8.sum} !== exp_res) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t: got busy=%b done=%b sum=%h c_out=%b ovf=%b, expected busy=%b done=%b sum=%h c_out=%b ovf=%b",
               $time, bus8.busy, bus8.done, bus8.sum, bus8.c_out, bus8.ovf,
               exp_busy, exp_done, exp_res[7:0], exp_res[8], exp_res[9]);
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic sub, output int lat);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.c_in = cin; bus8.sub = sub; bus8.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      bus8.start = 1'b0;
      lat++;
    end while (!bus8.done && lat < 40);
    check("op8_done_seen", longint'(bus8.done), 1);
  endtask

  task automatic op1(input logic a, input logic b, input logic cin, output int lat);
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.c_in = cin; bus1.sub = 1'b0; bus1.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      bus1.start = 1'b0;
      lat++;
    end while (!bus1.done && lat < 20);
    check("op1_done_seen", longint'(bus1.done), 1);
  endtask

  initial begin
    int lat;
    int last;
    int ndone;
    logic [9:0] r;
    bus8.start = 0; bus8.a = 0; bus8.b = 0; bus8.c_in = 0; bus8.sub = 0;
    bus1.start = 0; bus1.a = 0; bus1.b = 0; bus1.c_in = 0; bus1.sub = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", longint'(bus8.busy), 0);
    check("reset_done", longint'(bus8.done), 0);
    check("reset_sum", longint'(bus8.sum), 0);
    check("reset_cout_ovf", longint'({bus8.c_out, bus8.ovf}), 0);
    rst_n = 1'b1;

    // Literal expectations: carry out, then signed overflow
    op8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    check("lat_w8", lat, 9);
    check("ff_01_sum", longint'(bus8.sum), 8'h00);
    check("ff_01_cout", longint'(bus8.c_out), 1);
    check("ff_01_ovf", longint'(bus8.ovf), 0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    check("7f_01_sum", longint'(bus8.sum), 8'h80);
    check("7f_01_cout", longint'(bus8.c_out), 0);
    check("7f_01_ovf", longint'(bus8.ovf), 1);

    // Subtract request (plain add when the feature is absent)
    op8(8'h05, 8'h07, 1'b0, 1'b1, lat);
    check("sub_05_07_sum", longint'(bus8.sum), SUB_ON ? 8'hFE : 8'h0C);
    check("sub_05_07_cout_ovf", longint'({bus8.c_out, bus8.ovf}), 0);
    op8(8'h80, 8'h01, 1'b0, 1'b1, lat);
    check("sub_80_01_sum", longint'(bus8.sum), SUB_ON ? 8'h7F : 8'h81);
    check("sub_80_01_cout_ovf", longint'({bus8.c_out, bus8.ovf}), SUB_ON ? 2'b11 : 2'b00);

    // Operands change during SHIFT; result must reflect captured values
    @(negedge clk);
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.c_in = 0; bus8.sub = 0; bus8.start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.c_in = 1'($urandom);
      bus8.start = (k < 3);
    end
    check("hold_prev_sum", longint'(bus8.sum), SUB_ON ? 8'h7F : 8'h81);
    lat = 0;
    while (!bus8.done && lat < 20) begin @(negedge clk); lat++; end
    check("aa_55_sum", longint'(bus8.sum), 8'hFF);
    check("aa_55_cout", longint'(bus8.c_out), 0);

    // Start held continuously: one result every 9 cycles, no idle gap
    @(negedge clk);
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.c_in = 0; bus8.sub = 0; bus8.start = 1'b1;
    last = -1; ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        check("b2b_sum", longint'(bus8.sum), 8'h46);
        if (last >= 0) check("b2b_period", k - last, 9);
        last = k;
        ndone++;
      end
    end
    bus8.start = 1'b0;
    check("b2b_count", ndone, 4);
    lat = 0;
    while (!bus8.done && lat < 20) begin @(negedge clk); lat++; end

    // Asynchronous reset mid-SHIFT
    @(negedge clk);
    bus8.a = 8'hAA; bus8.b = 8'h11; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", longint'(bus8.busy), 0);
    check("arst_done", longint'(bus8.done), 0);
    check("arst_sum", longint'(bus8.sum), 0);
    check("arst_cout_ovf", longint'({bus8.c_out, bus8.ovf}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.done) ndone++;
    end
    check("no_done_after_reset", ndone, 0);
    op8(8'h03, 8'h04, 1'b1, 1'b0, lat);
    check("after_reset_sum", longint'(bus8.sum), 8'h08);

    // Randomized traffic, including start pulses while busy
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      bus8.start = ($urandom_range(0, 3) == 0);
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
      bus8.c_in  = 1'($urandom);
      bus8.sub   = 1'($urandom);
    end
    bus8.start = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=1: full-adder truth table, done two cycles after start
    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0], lat);
      r = ref_add(1, {7'd0, i[2]}, {7'd0, i[1]}, i[0], 1'b0);
      check("lat_w1", lat, 2);
      check("w1_sum", longint'(bus1.sum), longint'(r[0]));
      check("w1_cout", longint'(bus1.c_out), longint'(r[8]));
      check("w1_ovf", longint'(bus1.ovf), longint'(i[0] ^ r[8]));
    end
    check("w1_111_lit", longint'({bus1.c_out, bus1.sum}), 2'b11);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach the summary, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
